axil_slave_regs_wr: RTL and testbench

//  AXI-Lite write-channel responder: the slave end of the write path routed by the

---
 rtl/axil_slave_regs_wr.sv | 153 +++++++++++++++
 tb/tb_axil_slave_regs_wr.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_regs_wr.sv
// rtl/axil_slave_regs_wr.sv - AXI-Lite write-channel responder with byte-strobed register bank
package axil_pkg;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
endpackage

module axil_slave_regs_wr
  import axil_pkg::*;
#(
  parameter int                         NUM_REGS    = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter logic [NUM_REGS-1:0]        RO_MASK     = '0,
  parameter logic [AXI_DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  output logic [AXI_DATA_WIDTH-1:0]     reg_out [NUM_REGS],
  output logic [NUM_REGS-1:0]           reg_wr_pulse
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(NUM_REGS * STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic                      aw_full_q, aw_full_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                      w_full_q, w_full_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [AXI_DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]       pulse_q, pulse_d;

  logic                      aw_hs, w_hs, commit, in_range;
  logic [AXI_ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]          idx;
  logic [1:0]                resp;

  // Ready comes straight from the buffer-full flags so there is no input-to-ready path.
  assign s_axil_awready = !aw_full_q;
  assign s_axil_wready  = !w_full_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign reg_out        = regs_q;
  assign reg_wr_pulse   = pulse_q;

  assign aw_hs  = s_axil_awvalid && !aw_full_q;
  assign w_hs   = s_axil_wvalid && !w_full_q;
  // A commit needs both halves buffered and a free B slot (empty, or draining this cycle).
  assign commit = aw_full_q && w_full_q && (!bvalid_q || s_axil_bready);

  // Decode the buffered address into a register index and a response code.
  always_comb begin
    offset   = awaddr_q - BASE_ADDR;
    idx      = offset[IDX_W+LSB-1:LSB];
    in_range = (awaddr_q >= BASE_ADDR) && (offset < SPAN);
    if (!in_range) begin
      resp = RESP_DECERR;
    end else if (RO_MASK[idx]) begin
      resp = RESP_SLVERR;
    end else begin
      resp = RESP_OKAY;
    end
  end

  // Next state of the AW/W buffers and the B response slot.
  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = s_axil_awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end
    if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = resp;
    end
  end

  // Byte-strobed register update and the one-hot write pulse; error responses leave the bank alone.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (commit && (resp == RESP_OKAY)) begin
      pulse_d[idx] = 1'b1;
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) begin
          regs_d[idx][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
  end

  // State registers; reset discards any half-received transaction.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_full_q <= 1'b0;
      awaddr_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      aw_full_q <= aw_full_d;
      awaddr_q  <= awaddr_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_axil_slave_regs_wr.sv
// tb/tb_axil_slave_regs_wr.sv - scoreboard bench for axil_slave_regs_wr
module tb_axil_slave_regs_wr;
  import axil_pkg::*;

  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [15:0] RO   = 16'h0088;
  localparam logic [31:0] RV   = 32'h0000_0000;

  typedef struct packed {
    logic [1:0]        resp;
    logic [NR-1:0]     pulse;
    logic [NR*32-1:0]  snap;
  } exp_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] reg_out [NR];
  logic [NR-1:0] reg_wr_pulse;

  logic [1:0]  bready_mode;
  logic        rnd_bit;
  logic        b2b;

  int checks = 0;
  int passed = 0;
  exp_t q[$];
  logic [31:0] m_regs [NR];

  axil_slave_regs_wr #(
    .NUM_REGS(NR), .BASE_ADDR(BASE), .RO_MASK(RO), .RESET_VALUE(RV)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 aclk = ~aclk;

  assign bready = (bready_mode == 2'd2) ? rnd_bit : bready_mode[0];

  always @(posedge aclk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_snap(input string name, input logic [NR*32-1:0] exp);
    logic [NR*32-1:0] act;
    for (int i = 0; i < NR; i++) act[32*i +: 32] = reg_out[i];
    checks++;
    if (act === exp) passed++;
    else begin
      for (int i = 0; i < NR; i++) begin
        if (act[32*i +: 32] !== exp[32*i +: 32]) begin
          $display("FAIL %s reg[%0d] actual=%0h required=%0h at %0t", name, i,
                   act[32*i +: 32], exp[32*i +: 32], $time);
          break;
        end
      end
    end
  endtask

  function automatic logic [NR*32-1:0] model_snap();
    logic [NR*32-1:0] s;
    for (int i = 0; i < NR; i++) s[32*i +: 32] = m_regs[i];
    return s;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = RV;
  endfunction

  // Reference: decode by plain arithmetic on the byte address, merge strobed bytes.
  function automatic exp_t model_write(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb);
    exp_t e;
    int   idx;
    e.pulse = '0;
    if (addr < BASE || (addr - BASE) >= NR * 4) begin
      e.resp = 2'b11;
    end else begin
      idx = int'((addr - BASE) / 4);
      if (RO[idx]) e.resp = 2'b10;
      else begin
        e.resp = 2'b00;
        e.pulse[idx] = 1'b1;
        for (int b = 0; b < 4; b++)
          if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
    e.snap = model_snap();
    return e;
  endfunction

  task automatic send_aw(input logic [31:0] addr, input int dly);
    logic r;
    int   n = 0;
    if (dly > 0) begin repeat (dly) @(posedge aclk); #1; end
    awaddr = addr; awvalid = 1'b1;
    forever begin
      @(negedge aclk); r = awready;
      @(posedge aclk);
      if (r) break;
      n++;
      if (n > 200) begin check("aw_timeout", 1, 0); break; end
    end
    #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    logic r;
    int   n = 0;
    if (dly > 0) begin repeat (dly) @(posedge aclk); #1; end
    wdata = data; wstrb = strb; wvalid = 1'b1;
    forever begin
      @(negedge aclk); r = wready;
      @(posedge aclk);
      if (r) break;
      n++;
      if (n > 200) begin check("w_timeout", 1, 0); break; end
    end
    #1 wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd);
    q.push_back(model_write(addr, data, strb));
    fork
      send_aw(addr, awd);
      send_w(data, strb, wd);
    join
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin @(posedge aclk); n++; end
    #1;
    check("drain", 64'(q.size()), 0);
  endtask

  // Monitor: pops the scoreboard on every B handshake and checks pulse, hold and spacing rules.
  logic       prev_bv, prev_hs, b2b_seen;
  logic [1:0] prev_resp;
  int         cyc, last_new;
  always @(negedge aclk) begin : mon
    exp_t e;
    logic new_resp;
    cyc++;
    if (areset) begin
      prev_bv = 1'b0; prev_hs = 1'b0; b2b_seen = 1'b0;
    end else begin
      new_resp = bvalid && (!prev_bv || prev_hs);
      if (new_resp) begin
        if (q.size() == 0) check("unexpected_b", 1, 0);
        else check("pulse", 64'(reg_wr_pulse), 64'(q[0].pulse));
      end else begin
        check("pulse_idle", 64'(reg_wr_pulse), 0);
      end
      if (prev_bv && !prev_hs) begin
        check("b_hold_valid", 64'(bvalid), 1);
        check("b_hold_resp", 64'(bresp), 64'(prev_resp));
      end
      if (!b2b) b2b_seen = 1'b0;
      else if (new_resp) begin
        if (b2b_seen) check("b2b_spacing", 64'(cyc - last_new), 2);
        b2b_seen = 1'b1;
        last_new = cyc;
      end
      if (bvalid && bready && q.size() > 0) begin
        e = q.pop_front();
        check("bresp", 64'(bresp), 64'(e.resp));
        check_snap("regs_at_b", e.snap);
      end
      prev_bv = bvalid; prev_hs = bvalid && bready; prev_resp = bresp;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] held;
    int n;
    cyc = 0; last_new = 0; b2b = 1'b0; rnd_bit = 1'b0; bready_mode = 2'd1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    prev_bv = 1'b0; prev_hs = 1'b0; prev_resp = '0; b2b_seen = 1'b0;
    model_reset();
    areset = 1'b0;
    #1 areset = 1'b1;
    #1;
    check("rst_awready", 64'(awready), 1);
    check("rst_wready", 64'(wready), 1);
    check("rst_bvalid", 64'(bvalid), 0);
    check("rst_bresp", 64'(bresp), 0);
    check("rst_pulse", 64'(reg_wr_pulse), 0);
    check_snap("rst_regs", model_snap());
    @(posedge aclk); #3 areset = 1'b0;
    @(posedge aclk); #1;

    // Same-cycle AW/W, then latency: B and register appear one edge after the handshake.
    do_write(BASE, 32'hDEAD_BEEF, 4'hF, 0, 0);
    check("lat_bvalid_early", 64'(bvalid), 0);
    check("lat_reg_early", 64'(reg_out[0]), 64'(RV));
    @(posedge aclk); #1;
    check("lat_bvalid", 64'(bvalid), 1);
    check("lat_reg0", 64'(reg_out[0]), 64'h DEAD_BEEF);
    drain();

    // W first, AW three cycles later, partial strobes.
    do_write(BASE + 32'd8, 32'h1122_3344, 4'b0101, 3, 0);
    drain();
    check("reg2_strobed", 64'(reg_out[2]), 64'h0022_0044);

    // Decode error above and below the bank, and a read-only register.
    do_write(BASE + NR * 4, 32'h1234_5678, 4'hF, 0, 1);
    do_write(BASE - 32'd4, 32'h1234_5678, 4'hF, 1, 0);
    do_write(BASE + 32'd12, 32'hCAFE_F00D, 4'hF, 0, 0);
    drain();
    check("ro_reg3", 64'(reg_out[3]), 64'(RV));

    // Backpressure: B held, a second write fills both buffers, then ready drops.
    bready_mode = 2'd0;
    do_write(BASE + 32'd4, 32'hA5A5_5A5A, 4'hF, 0, 0);
    n = 0;
    while (!bvalid && n < 50) begin @(posedge aclk); n++; end
    #1;
    check("bp_bvalid", 64'(bvalid), 1);
    held = bresp;
    repeat (5) begin @(posedge aclk); #1; check("bp_resp_stable", 64'(bresp), 64'(held)); end
    do_write(BASE + 32'd16, 32'h0BAD_F00D, 4'hC, 0, 0);
    repeat (3) begin
      @(posedge aclk); #1;
      check("bp_awready", 64'(awready), 0);
      check("bp_wready", 64'(wready), 0);
    end
    bready_mode = 2'd1;
    drain();

    // Back-to-back writes with bready high: one commit every two cycles.
    b2b = 1'b1;
    for (int i = 0; i < 6; i++)
      do_write(BASE + 32'(4 * ((i * 5) % NR)), $urandom, 4'($urandom_range(0, 15)), 0, 0);
    drain();
    b2b = 1'b0;

    // Randomized traffic with random bready and channel skew.
    bready_mode = 2'd2;
    for (int i = 0; i < 40; i++)
      do_write(BASE - 32'd16 + 32'($urandom_range(0, 96)), $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3));
    bready_mode = 2'd1;
    drain();

    // Reset with only AW held: ready returns at once, bank resets, no B follows.
    send_aw(BASE + 32'd4, 0);
    check("pre_rst_awready", 64'(awready), 0);
    #2 areset = 1'b1;
    #1;
    check("arst_awready", 64'(awready), 1);
    check("arst_wready", 64'(wready), 1);
    model_reset();
    check_snap("arst_regs", model_snap());
    @(posedge aclk); #3 areset = 1'b0;
    repeat (10) @(posedge aclk);
    #1;
    check("arst_no_b", 64'(bvalid), 0);
    do_write(BASE + 32'd20, 32'h7777_8888, 4'hF, 0, 2);
    drain();
    check_snap("final_regs", model_snap());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
